router_sync_ctrl: RTL

//  Glue controller between the 1x3 router input FSM and the three output FIFOs.
//  - Latches the destination address at header time.
//  - Steers the FSM write request to one FIFO and returns that FIFO's full flag.
//  - Raises per-port valid outputs.
//  - Drives a per-port soft reset when a destination leaves its packet unread for TIMEOUT cycles.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_timeout_cnt.sv | 63 ++++++
 rtl/router_sync_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath, address decode and FIFO glue.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    localparam int TIMEOUT_DEFAULT = 30;
    localparam int CNT_W_DEFAULT   = 8;

    typedef logic [ADDR_W-1:0] port_idx_t;

    function automatic logic addr_is_valid(input port_idx_t addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_timeout_cnt.sv
// Per-port idle watchdog: pulses soft_rst after TIMEOUT consecutive valid-but-unread cycles.
// ROUTER_SYNC_DROP_CNT_EN adds a saturating count of those pulses on drop_cnt.
module router_timeout_cnt
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd_en,
    output logic soft_rst
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT - 1);

    logic             w_idle;
    logic             w_fire;
    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_rst;

    assign w_idle = vld & ~rd_en;
    // Fires on the TIMEOUT-th consecutive idle cycle; a read on that cycle cancels it.
    assign w_fire = w_idle && (r_cnt == LAST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
        end else if (!w_idle) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
        end else if (w_fire) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b1;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_soft_rst <= 1'b0;
        end
    end

    assign soft_rst = r_soft_rst;

`ifdef ROUTER_SYNC_DROP_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_fire && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: rtl/router_sync_ctrl.sv
// Router synchronizer: header address latch, FIFO write steering, valid flags and soft resets.
// Optional macro ROUTER_SYNC_DROP_CNT_EN exposes per-port soft-reset counts on drop_cnt.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  detect_addr,
    input  logic [ADDR_W-1:0]     din,
    input  logic                  wr_en_req,
    input  logic [NUM_PORTS-1:0]  rd_en,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  fifo_full_in,
    output logic [NUM_PORTS-1:0]  write_enb,
    output logic                  fifo_full,
    output logic [NUM_PORTS-1:0]  vld_out,
    output logic [NUM_PORTS-1:0]  soft_rst
`ifdef ROUTER_SYNC_DROP_CNT_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0] drop_cnt
`endif
);

    port_idx_t r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= ADDR_INVALID;
        end else if (detect_addr) begin
            r_addr <= din;
        end
    end

    // Steering uses the registered address, so a same-cycle capture only affects later writes.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        if (addr_is_valid(r_addr)) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    write_enb[i] = wr_en_req;
                    fifo_full    = fifo_full_in[i];
                end
            end
        end
    end

    assign vld_out = ~fifo_empty;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        router_timeout_cnt #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timeout (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld_out[g]),
            .rd_en    (rd_en[g]),
            .soft_rst (soft_rst[g])
`ifdef ROUTER_SYNC_DROP_CNT_EN
            ,
            .drop_cnt (drop_cnt[g*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
